// File: rtl/print_seq.sv
// Character-RAM to UART byte sequencer.
// Streams NUL-terminated text MSB-first, one RAM word at a time.
module print_seq #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int DEPL2 = 4
) (
  input  logic             clk_i,
  input  logic             nrst_i,
  input  logic             start_i,
  output logic [DEPL2-1:0] addr_o,
  input  logic [WIDTH-1:0] data_i,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic             busy_o,
  output logic             done_o
);

  localparam int NB = WIDTH / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SEND,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [DEPL2-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [IW-1:0]    idx_q, idx_d;

  logic [WIDTH-1:0] shifted;
  logic [7:0]       nxt_byte;
  logic             xfer;
  logic             last_b;
  logic             last_w;

  assign shifted  = sreg_q << 8;
  assign nxt_byte = shifted[WIDTH-1 -: 8];
  assign xfer     = (state_q == SEND) && tx_ready_i;
  assign last_b   = (idx_q == IW'(NB - 1));
  assign last_w   = (addr_q == DEPL2'(DEPTH - 1));

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      sreg_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sreg_q  <= sreg_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sreg_d  = sreg_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d  = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        sreg_d  = data_i;
        idx_d   = '0;
        state_d = (data_i[WIDTH-1 -: 8] == 8'h00) ? DONE : SEND;
      end
      SEND: begin
        if (xfer) begin
          if (!last_b) begin
            sreg_d  = shifted;
            idx_d   = idx_q + IW'(1);
            state_d = (nxt_byte == 8'h00) ? DONE : SEND;
          end else if (last_w) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + DEPL2'(1);
            state_d = FETCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign addr_o     = addr_q;
  assign tx_data_o  = sreg_q[WIDTH-1 -: 8];
  assign tx_valid_o = (state_q == SEND);
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);

endmodule

// File: tb/tb_print_seq.sv
// Scoreboard bench for print_seq.
// Stimulus queues expected bytes; a negedge monitor checks them.
module tb_print_seq;

  logic        clk_i = 1'b0;
  logic        nrst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        tx_ready_i = 1'b1;
  logic [3:0]  addr_o;
  logic [63:0] data_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        busy_o;
  logic        done_o;

  print_seq #(
    .WIDTH(64),
    .DEPTH(16),
    .DEPL2(4)
  ) dut (
    .clk_i     (clk_i),
    .nrst_i    (nrst_i),
    .start_i   (start_i),
    .addr_o    (addr_o),
    .data_i    (data_i),
    .tx_data_o (tx_data_o),
    .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk_i = ~clk_i;

  logic [63:0] mem [16];
  always @(posedge clk_i) data_i <= mem[addr_o];

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q [$];
  logic [7:0] exp_b;
  int         done_cycles = 0;
  int         gap_cycles = 0;
  int         wrap_errs = 0;
  int         max_addr = 0;
  bit         rdy_rand = 1'b0;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_busy = 1'b0;
  logic [3:0] prev_addr = 4'd0;

  // monitor: byte scoreboard, stall stability, pass statistics
  always @(negedge clk_i) begin
    if (tx_valid_o && tx_ready_i) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL tx_byte: got %02h, expected no byte", tx_data_o);
      end else begin
        exp_b = exp_q.pop_front();
        if (tx_data_o !== exp_b) begin
          miscompares++;
          $display("FAIL tx_byte: got %02h, expected %02h", tx_data_o, exp_b);
        end
      end
    end
    if (prev_hold && tx_valid_o) begin
      vectors++;
      if (tx_data_o !== prev_data) begin
        miscompares++;
        $display("FAIL tx_stable: got %02h, expected %02h", tx_data_o, prev_data);
      end
    end
    prev_hold = tx_valid_o && !tx_ready_i;
    prev_data = tx_data_o;
    if (done_o) done_cycles++;
    if (busy_o && !tx_valid_o && !done_o) gap_cycles++;
    if (busy_o && prev_busy && addr_o < prev_addr) wrap_errs++;
    if (busy_o && int'(addr_o) > max_addr) max_addr = int'(addr_o);
    prev_busy = busy_o;
    prev_addr = addr_o;
  end

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      tx_ready_i = rdy_rand ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    done_cycles = 0;
    gap_cycles  = 0;
    wrap_errs   = 0;
    max_addr    = 0;
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic pulse_start();
    @(posedge clk_i);
    #1 start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (done_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic load_hello();
    for (int w = 0; w < 16; w++) mem[w] = 64'h0;
    mem[0] = 64'h48656C6C6F2C2057;
    mem[1] = 64'h6F726C640A000000;
  endtask

  bit         ok;
  bit         hit;
  logic [7:0] b;

  initial begin
    load_hello();
    #2;
    check("rst_addr", addr_o, 0);
    check("rst_txdata", tx_data_o, 0);
    check("rst_valid", tx_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    repeat (2) @(posedge clk_i);
    #1 nrst_i = 1'b1;

    // hello world, ready always high
    clear_stats();
    push_str("Hello, World\n");
    pulse_start();
    @(negedge clk_i);
    check("a_busy_n", busy_o, 1);
    check("a_addr_n", addr_o, 0);
    @(negedge clk_i);
    check("a_valid_n1", tx_valid_o, 0);
    @(negedge clk_i);
    check("a_valid_n2", tx_valid_o, 1);
    wait_done(200, ok);
    check("a_done_seen", ok, 1);
    check("a_addr_end", addr_o, 1);
    @(negedge clk_i);
    check("a_busy_fall", busy_o, 0);
    check("a_done_cycles", done_cycles, 1);
    check("a_gap_cycles", gap_cycles, 4);
    check("a_max_addr", max_addr, 1);
    check("a_queue_left", exp_q.size(), 0);

    // all 16 words full, no terminator
    clear_stats();
    for (int w = 0; w < 16; w++) begin
      for (int k = 0; k < 8; k++) begin
        b = 8'h21 + 8'((w * 8 + k) % 90);
        mem[w] = {mem[w][55:0], b};
        exp_q.push_back(b);
      end
    end
    pulse_start();
    wait_done(400, ok);
    check("b_done_seen", ok, 1);
    check("b_addr_end", addr_o, 15);
    @(negedge clk_i);
    check("b_busy_fall", busy_o, 0);
    check("b_done_cycles", done_cycles, 1);
    check("b_fetch_cycles", gap_cycles / 2, 16);
    check("b_wrap_errs", wrap_errs, 0);
    check("b_max_addr", max_addr, 15);
    check("b_queue_left", exp_q.size(), 0);

    // empty string
    clear_stats();
    for (int w = 0; w < 16; w++) mem[w] = 64'h0;
    mem[0] = 64'h0048656C6C6F2121;
    pulse_start();
    @(negedge clk_i);
    check("c_busy_n", busy_o, 1);
    @(negedge clk_i);
    check("c_done_n1", done_o, 0);
    @(negedge clk_i);
    check("c_done_n2", done_o, 1);
    check("c_valid_n2", tx_valid_o, 0);
    check("c_addr_n2", addr_o, 0);
    @(negedge clk_i);
    check("c_busy_fall", busy_o, 0);
    check("c_done_cycles", done_cycles, 1);

    // random backpressure
    clear_stats();
    load_hello();
    rdy_rand = 1'b1;
    push_str("Hello, World\n");
    pulse_start();
    wait_done(2000, ok);
    check("d_done_seen", ok, 1);
    @(negedge clk_i);
    rdy_rand = 1'b0;
    check("d_done_cycles", done_cycles, 1);
    check("d_queue_left", exp_q.size(), 0);

    // reset while presenting byte 3 of word 1
    push_str("Hello, Worl");
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_i);
      #1;
      if (tx_valid_o && addr_o == 4'd1 && tx_data_o == 8'h64) begin
        hit = 1'b1;
        break;
      end
    end
    check("e_reached_d", hit, 1);
    nrst_i = 1'b0;
    #1;
    check("e_rst_valid", tx_valid_o, 0);
    check("e_rst_busy", busy_o, 0);
    check("e_rst_addr", addr_o, 0);
    check("e_rst_txdata", tx_data_o, 0);
    check("e_rst_done", done_o, 0);
    start_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 start_i = 1'b0;
    check("e_hold_busy", busy_o, 0);
    nrst_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    check("e_idle_valid", tx_valid_o, 0);
    check("e_idle_busy", busy_o, 0);
    check("e_queue_left", exp_q.size(), 0);

    // start on first edge after release; starts while busy ignored
    nrst_i = 1'b0;
    @(posedge clk_i);
    #1;
    clear_stats();
    push_str("Hello, World\n");
    nrst_i  = 1'b1;
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    @(negedge clk_i);
    check("f_busy_first", busy_o, 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_i);
      #1 start_i = (i % 2 == 0);
    end
    start_i = 1'b0;
    wait_done(200, ok);
    check("f_done_seen", ok, 1);
    @(negedge clk_i);
    check("f_busy_fall", busy_o, 0);
    check("f_done_cycles", done_cycles, 1);
    check("f_queue_left", exp_q.size(), 0);
    repeat (4) @(negedge clk_i);
    check("f_no_restart", busy_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/print_seq.md
PRINT_SEQ -- requirements
Module: print_seq

Interface
REQ-001 Parameter WIDTH, default 64: bits per character-RAM word; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 16: number of character-RAM words scanned.
REQ-003 Parameter DEPL2, default 4: address width, with DEPTH <= 2**DEPL2.
REQ-004 clk_i  input  1  single clock; all state SHALL change on its rising edge.
REQ-005 nrst_i  input  1  reset, asynchronous, active-low.
REQ-006 start_i  input  1  begin a print pass; sampled in IDLE only.
REQ-007 addr_o  output  DEPL2  read address to the character RAM.
REQ-008 data_i  input  WIDTH  character-RAM read data; valid one clock after addr_o is presented.
REQ-009 tx_data_o  output  8  byte to the UART transmitter.
REQ-010 tx_valid_o  output  1  tx_data_o is valid.
REQ-011 tx_ready_i  input  1  transmitter accepts the byte; transfer occurs on an edge with tx_valid_o and tx_ready_i both high.
REQ-012 busy_o  output  1  a pass is in progress.
REQ-013 done_o  output  1  one-cycle pulse when a pass ends.

Function
REQ-014 The FSM SHALL have the states IDLE, FETCH, LOAD, SEND and DONE.
REQ-015 IDLE with start_i=1: the block SHALL set addr_o<=0 and go to FETCH; start_i SHALL be ignored in all other states.
REQ-016 FETCH: the block SHALL hold addr_o for one cycle, then go to LOAD.
REQ-017 LOAD: the block SHALL capture data_i into a WIDTH-bit shift register and reset the byte index to 0.
REQ-018 Byte order SHALL be MSB first: bits [WIDTH-1:WIDTH-8] are sent first.
REQ-019 LOAD exit: if the first byte is 0x00, go to DONE; otherwise go to SEND with tx_data_o = first byte.
REQ-020 tx_valid_o SHALL be high exactly while in SEND; tx_data_o SHALL stay stable while tx_valid_o=1 and tx_ready_i=0.
REQ-021 On a transfer when the byte index is below WIDTH/8-1, the block SHALL:
  - shift left 8;
  - increment the index;
  - go to DONE if the new byte is 0x00 (NUL terminator, not transmitted);
  - otherwise stay in SEND with the new byte.
REQ-022 On a transfer of the last byte of a word: if addr_o = DEPTH-1, go to DONE; otherwise addr_o <= addr_o+1 and go to FETCH.
REQ-023 addr_o SHALL never wrap; a pass SHALL read at most DEPTH words.
REQ-024 DONE: done_o SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; tx_valid_o SHALL be 0.
REQ-025 busy_o SHALL be 1 in FETCH, LOAD, SEND and DONE, and 0 in IDLE.
REQ-026 Latency: with start_i sampled at edge n, tx_valid_o SHALL rise after edge n+2.
REQ-027 Latency: after each last-byte transfer at edge m, the next word's tx_valid_o SHALL rise after edge m+2.
REQ-028 Throughput: with tx_ready_i held high, one byte SHALL transfer per cycle within a word.

Reset
REQ-029 While nrst_i=0, regardless of clk_i, the block SHALL hold: state=IDLE, addr_o=0, tx_data_o=0x00, tx_valid_o=0, busy_o=0, done_o=0, shift register=0, byte index=0.
REQ-030 Reset mid-pass SHALL abandon the pass; no byte is presented after release until a new start_i.
REQ-031 The first start_i SHALL be honoured on the first edge after nrst_i deasserts.

Verification
REQ-032 The bench SHALL model a 1-cycle-latency RAM. Word0=0x48656C6C6F2C2057 and word1=0x6F726C640A000000, tx_ready_i=1, start pulse ->
  - 13 bytes sent: "Hello, World\n";
  - addr_o values 0 then 1;
  - done_o one pulse; busy_o falls after it.
REQ-033 All 16 words with no 0x00 byte ->
  - 128 bytes sent;
  - addr_o runs 0..15 and stops at 15 (no wrap);
  - exactly 16 FETCH cycles.
REQ-034 Word0 first byte = 0x00 -> no tx_valid_o; done_o pulses after edge n+2; addr_o=0.
REQ-035 tx_ready_i random (about 30% high) -> no byte lost or duplicated; tx_data_o stable while tx_valid_o=1 and tx_ready_i=0.
REQ-036 nrst_i pulsed low while sending byte 3 of word 1 ->
  - outputs go to reset values immediately;
  - a new start sends from word 0 byte 0;
  - start_i pulses while busy_o=1 are ignored.
